sprite_line_fetcher: RTL
========================

Name: sprite_line_fetcher

Overview:
Fetches one 64-pixel row of a 64x64, 4 bpp sprite from the sprite ROM wrapper, which has a 16-bit data port and 2-cycle read latency. It unpacks each 16-bit word into four 4-bit palette indices and stores them in an internal 64-entry line buffer. The display pipeline reads the buffer by x-coordinate. It sits between the row scheduler (start/sprite/row request) and the sprite ROM wrapper (sprite_sel/word_addr out, data in).

Parameters:
ROM_LATENCY, 2, cycles from word address driven to matching rom_data_i valid; legal range 1..4.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
start_i  input  1  fetch request; sampled only when busy_o=0.
sprite_sel_i  input  3  sprite index 0..6, latched on start.
row_i  input  6  sprite row 0..63, latched on start.
busy_o  output  1  high while a fetch is in progress.
done_o  output  1  one-cycle pulse when the line buffer is complete.
rom_sprite_sel_o  output  3  sprite select to the ROM wrapper.
rom_word_addr_o  output  10  word address to the ROM wrapper.
rom_data_i  input  16  ROM read data.
pix_x_i  input  6  line-buffer read x-coordinate.
pix_o  output  4  palette index at pix_x_i, registered.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - busy_o=0, done_o=0, rom_sprite_sel_o=0, rom_word_addr_o=0, pix_o=0.
  - Word counter and latency tag pipeline are cleared.
  - Line buffer contents are not cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start_i=1 at edge E0 latches sprite_sel_i and row_i, clears word index k, and goes to ISSUE.
  - ISSUE: for k=0..15, rom_word_addr_o={row,k[3:0]} is driven during cycle k+1. After k=15 the state goes to DRAIN.
  - DRAIN: waits until the last tagged word is written, then goes to DONE.
  - DONE: one cycle with done_o=1 and busy_o=0, then IDLE.
- Address and select outputs:
  - rom_word_addr_o is row*16+k. It never exceeds 0x3FF, so there is no wrap.
  - rom_sprite_sel_o holds the latched sprite for the whole of ISSUE, DRAIN and DONE, because the ROM wrapper uses a delayed copy of its select on the return data.
  - Outside a fetch, rom_sprite_sel_o and rom_word_addr_o hold their last values.
- Return-data capture:
  - A ROM_LATENCY-deep shift register carries {valid, k} for each issued address.
  - The word for index k is valid during cycle k+1+ROM_LATENCY and is written at the end of that cycle.
  - Unpacking of word k:
    - bits[15:12] go to pixel 4k
    - bits[11:8] go to pixel 4k+1
    - bits[7:4] go to pixel 4k+2
    - bits[3:0] go to pixel 4k+3
- Timing with ROM_LATENCY=2:
  - busy_o is high in cycles 1..18.
  - The last write happens at the end of cycle 18.
  - done_o pulses in cycle 19.
- Start handling:
  - start_i while busy_o=1 is ignored: no relatch, no restart.
  - start_i during the DONE cycle is accepted, and the next fetch's ISSUE begins the following cycle.
- Read port:
  - pix_o <= buffer[pix_x_i] every cycle, so there is 1-cycle read latency.
  - A read during a fetch returns current contents, which may be a mix of old and new words.
  - If a read and a write hit the same entry in the same cycle, pix_o returns the old value.
- Reset mid-fetch: aborts immediately. Partially written buffer contents remain and no done_o is produced.

Test Plan:
1. Assert reset mid-simulation with outputs nonzero -> busy_o, done_o, pix_o, rom_word_addr_o and rom_sprite_sel_o go to 0 asynchronously, before the next edge.
2. ROM model with 2-cycle latency returning word={addr[5:0],addr[9:0]}; start with sprite=2, row=5 -> rom_word_addr_o steps 0x050..0x05F in cycles 1..16, rom_sprite_sel_o=2 throughout, done_o only in cycle 19, busy_o high in cycles 1..18.
3. After scenario 2, sweep pix_x_i 0..63 -> each pix_o equals the expected nibble of the model word, e.g. pix_x=0 gives 0x4 (word 0x4050, bits[15:12]) and pix_x=3 gives 0x0.
4. Row 63, sprite 6 -> addresses 0x3F0..0x3FF with no wrap and no out-of-range value; done_o in cycle 19.
5. start_i pulsed in cycles 5 and 18 with different sprite/row -> ignored, addresses unchanged; start_i in the done_o cycle -> new fetch begins ISSUE the next cycle with the new row.
6. Reset asserted in cycle 10 of a fetch -> no done_o, state IDLE; a fresh fetch then completes normally, done_o in its cycle 19.

Source files
------------

// File: rtl/sprite_line_fetcher.sv
// Sprite row fetcher: reads 16 ROM words for one 64-pixel, 4 bpp row,
// unpacks them into a 64-entry line buffer and serves registered reads.
module sprite_line_fetcher #(
    parameter int ROM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [2:0]  sprite_sel_i,
    input  logic [5:0]  row_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  rom_sprite_sel_o,
    output logic [9:0]  rom_word_addr_o,
    input  logic [15:0] rom_data_i,
    input  logic [5:0]  pix_x_i,
    output logic [3:0]  pix_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]             r_state;
    logic [5:0]             r_row;
    logic [3:0]             r_k;
    logic [2:0]             r_sel;
    logic [9:0]             r_addr;
    logic [ROM_LATENCY-1:0] r_tag_v;
    logic [3:0]             r_tag_k [ROM_LATENCY];
    logic [3:0]             r_buf   [64];
    logic [3:0]             r_pix;

    logic       w_start;
    logic       w_issue;
    logic       w_wr;
    logic [3:0] w_wr_k;
    logic       w_last;

    // DONE behaves like IDLE for new requests so fetches can chain
    assign w_start = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_issue = (r_state == S_ISSUE);
    assign w_wr    = r_tag_v[ROM_LATENCY-1];
    assign w_wr_k  = r_tag_k[ROM_LATENCY-1];
    assign w_last  = w_wr && (w_wr_k == 4'hF);

    assign busy_o           = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign done_o           = (r_state == S_DONE);
    assign rom_sprite_sel_o = r_sel;
    assign rom_word_addr_o  = r_addr;
    assign pix_o            = r_pix;

    // Fetch sequencing: latch request, step word index, wait for last word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_row   <= 6'd0;
            r_k     <= 4'd0;
            r_sel   <= 3'd0;
            r_addr  <= 10'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_sel   <= sprite_sel_i;
                        r_row   <= row_i;
                        r_k     <= 4'd0;
                        r_addr  <= {row_i, 4'd0};
                        r_state <= S_ISSUE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (r_k == 4'hF) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_k    <= r_k + 4'd1;
                        r_addr <= {r_row, r_k + 4'd1};
                    end
                end
                S_DRAIN: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag pipeline tracks which word index returns from the ROM each cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_v <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_tag_k[i] <= 4'd0;
            end
        end else begin
            r_tag_v[0] <= w_issue;
            r_tag_k[0] <= r_k;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_k[i] <= r_tag_k[i-1];
            end
        end
    end

    // Line buffer write: one ROM word fills four consecutive pixels
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[{w_wr_k, 2'd0}] <= rom_data_i[15:12];
            r_buf[{w_wr_k, 2'd1}] <= rom_data_i[11:8];
            r_buf[{w_wr_k, 2'd2}] <= rom_data_i[7:4];
            r_buf[{w_wr_k, 2'd3}] <= rom_data_i[3:0];
        end
    end

    // Registered read port; a same-cycle write is seen one read later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix <= 4'd0;
        end else begin
            r_pix <= r_buf[pix_x_i];
        end
    end

endmodule
